// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled SPI slave with one-word TX buffer and RX holding register
module spi_slave_core #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{1'b1}}
) (
    input  logic                  I_CLK,
    input  logic                  I_RESETN,
    input  logic                  SCLK_SLAVE,
    input  logic                  SS_N_SLAVE,
    input  logic                  MOSI_SLAVE,
    output logic                  MISO_SLAVE,
    output logic                  MISO_OE,
    input  logic                  I_TX_EN,
    input  logic [DATA_WIDTH-1:0] I_WDATA,
    output logic                  O_TX_READY,
    input  logic                  I_RX_EN,
    output logic [DATA_WIDTH-1:0] O_RDATA,
    output logic                  O_RX_VALID,
    input  logic                  I_CLR_ERR,
    output logic                  O_OVERRUN,
    output logic                  O_UNDERRUN,
    output logic                  O_BUSY
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
    localparam logic CPOL_L = 1'(CPOL);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, tx_buf;
    logic                  tx_full;

    logic leading, trailing, ss_fall, ss_rise, in_shift;
    logic sample_edge, shift_edge, word_done, reload, load_now;
    logic [DATA_WIDTH-1:0] rx_word, load_word;

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            sclk_sync <= {SYNC_STAGES{CPOL_L}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= CPOL_L;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK_SLAVE};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N_SLAVE};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_SLAVE};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign leading  = (sclk_s != sclk_d) && (sclk_s != CPOL_L);
    assign trailing = (sclk_s != sclk_d) && (sclk_s == CPOL_L);
    assign ss_fall  = ss_d && !ss_s;
    assign ss_rise  = !ss_d && ss_s;
    assign in_shift = (state == SHIFT) && !ss_rise;

    // bit_cnt counts sampling edges; in CPHA=1 the first leading edge of a word has nothing to shift
    assign sample_edge = (CPHA != 0) ? trailing : leading;
    assign shift_edge  = (CPHA != 0) ? (leading && bit_cnt != '0) : (trailing && bit_cnt != FULL);
    assign word_done   = in_shift && sample_edge && (bit_cnt == LAST);
    assign reload      = in_shift && trailing && (bit_cnt == ((CPHA != 0) ? LAST : FULL));
    assign load_now    = ((state == LOAD) && !ss_rise) || reload;
    assign rx_word     = {rx_sr[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        load_word = IDLE_WORD;
        if (tx_full)
            load_word = tx_buf;
        else if (I_TX_EN)
            load_word = I_WDATA;
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_sr      <= '1;
            rx_sr      <= '0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            O_RDATA    <= '0;
            O_RX_VALID <= 1'b0;
            O_OVERRUN  <= 1'b0;
            O_UNDERRUN <= 1'b0;
        end else begin
            if (ss_rise)
                state <= IDLE;
            else if (state == IDLE && ss_fall)
                state <= LOAD;
            else if (state == LOAD)
                state <= SHIFT;

            if (load_now)
                bit_cnt <= '0;
            else if (in_shift && sample_edge)
                bit_cnt <= bit_cnt + CW'(1);

            if (in_shift && sample_edge)
                rx_sr <= rx_word;

            if (ss_rise)
                tx_sr <= '1;
            else if (load_now)
                tx_sr <= load_word;
            else if (in_shift && shift_edge)
                tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b1};

            // a write in the load cycle with an empty buffer bypasses into tx_sr and is not buffered
            if (load_now && tx_full)
                tx_full <= 1'b0;
            else if (I_TX_EN && !tx_full && !load_now) begin
                tx_buf  <= I_WDATA;
                tx_full <= 1'b1;
            end

            if (word_done && (!O_RX_VALID || I_RX_EN)) begin
                O_RDATA    <= rx_word;
                O_RX_VALID <= 1'b1;
            end else if (I_RX_EN)
                O_RX_VALID <= 1'b0;

            O_OVERRUN  <= (word_done && O_RX_VALID && !I_RX_EN) || (O_OVERRUN && !I_CLR_ERR);
            O_UNDERRUN <= (load_now && !tx_full && !I_TX_EN) || (O_UNDERRUN && !I_CLR_ERR);
        end
    end

    assign MISO_SLAVE = tx_sr[DATA_WIDTH-1];
    assign MISO_OE    = (state == SHIFT);
    assign O_TX_READY = !tx_full;
    assign O_BUSY     = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - randomized bench for spi_slave_core in modes 0 and 3
module tb_spi_slave_core;

    localparam int H  = 8;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sclk, ss_n, mosi, tx_en, rx_en, clr;
    logic [15:0] wdata;
    wire  [15:0] rdata;
    wire  [1:0]  miso, oe, txr, rxv, ovr, und, busy;

    int checks = 0;
    int errors = 0;

    bit         m_full [2];
    logic [7:0] m_buf [2];
    bit         m_rxv [2];
    logic [7:0] m_rdata [2];
    bit         m_ovr [2];
    bit         m_und [2];

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(SS), .IDLE_WORD(8'hFF)) u_m0 (
        .I_CLK(clk), .I_RESETN(rst_n), .SCLK_SLAVE(sclk[0]), .SS_N_SLAVE(ss_n[0]),
        .MOSI_SLAVE(mosi[0]), .MISO_SLAVE(miso[0]), .MISO_OE(oe[0]), .I_TX_EN(tx_en[0]),
        .I_WDATA(wdata[7:0]), .O_TX_READY(txr[0]), .I_RX_EN(rx_en[0]), .O_RDATA(rdata[7:0]),
        .O_RX_VALID(rxv[0]), .I_CLR_ERR(clr[0]), .O_OVERRUN(ovr[0]), .O_UNDERRUN(und[0]),
        .O_BUSY(busy[0])
    );

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(SS), .IDLE_WORD(8'hFF)) u_m3 (
        .I_CLK(clk), .I_RESETN(rst_n), .SCLK_SLAVE(sclk[1]), .SS_N_SLAVE(ss_n[1]),
        .MOSI_SLAVE(mosi[1]), .MISO_SLAVE(miso[1]), .MISO_OE(oe[1]), .I_TX_EN(tx_en[1]),
        .I_WDATA(wdata[15:8]), .O_TX_READY(txr[1]), .I_RX_EN(rx_en[1]), .O_RDATA(rdata[15:8]),
        .O_RX_VALID(rxv[1]), .I_CLR_ERR(clr[1]), .O_OVERRUN(ovr[1]), .O_UNDERRUN(und[1]),
        .O_BUSY(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_buf[i] = 8'h00; m_rxv[i] = 0;
            m_rdata[i] = 8'h00; m_ovr[i] = 0; m_und[i] = 0;
        end
    endtask

    // word the slave must put on MISO for the next frame, from buffer / bypass / idle rules
    task automatic model_load(input int u, input bit byp, input logic [7:0] bd, output logic [7:0] w);
        if (m_full[u]) begin
            w = m_buf[u];
            m_full[u] = 0;
        end else if (byp) begin
            w = bd;
        end else begin
            w = 8'hFF;
            m_und[u] = 1;
        end
    endtask

    task automatic model_done(input int u, input logic [7:0] word);
        if (!m_rxv[u]) begin
            m_rdata[u] = word;
            m_rxv[u] = 1;
        end else begin
            m_ovr[u] = 1;
        end
    endtask

    task automatic check_status(input int u, input string tag);
        check({tag, "_txready"}, 32'(txr[u]), 32'(!m_full[u]));
        check({tag, "_rxvalid"}, 32'(rxv[u]), 32'(m_rxv[u]));
        check({tag, "_overrun"}, 32'(ovr[u]), 32'(m_ovr[u]));
        check({tag, "_underrun"}, 32'(und[u]), 32'(m_und[u]));
    endtask

    task automatic host_write(input int u, input logic [7:0] d);
        tx_en[u] = 1'b1;
        wdata[u*8 +: 8] = d;
        if (!m_full[u]) begin
            m_full[u] = 1;
            m_buf[u] = d;
        end
        @(negedge clk);
        tx_en[u] = 1'b0;
    endtask

    task automatic host_read(input int u);
        check("read_valid", 32'(rxv[u]), 32'(m_rxv[u]));
        if (m_rxv[u])
            check("read_data", 32'(rdata[u*8 +: 8]), 32'(m_rdata[u]));
        rx_en[u] = 1'b1;
        m_rxv[u] = 0;
        @(negedge clk);
        rx_en[u] = 1'b0;
    endtask

    task automatic host_clear(input int u);
        clr[u] = 1'b1;
        m_ovr[u] = 0;
        m_und[u] = 0;
        @(negedge clk);
        clr[u] = 1'b0;
    endtask

    task automatic select(input int u, input bit byp, input logic [7:0] bd, output logic [7:0] w);
        ss_n[u] = 1'b0;
        wait_clk(SS + 1);
        check("load_busy", 32'(busy[u]), 32'd1);
        if (byp) begin
            tx_en[u] = 1'b1;
            wdata[u*8 +: 8] = bd;
        end
        @(negedge clk);
        tx_en[u] = 1'b0;
        model_load(u, byp, bd, w);
        wait_clk(4);
        check("select_oe", 32'(oe[u]), 32'd1);
    endtask

    task automatic deselect(input int u);
        ss_n[u] = 1'b1;
        wait_clk(SS + 3);
        check("desel_oe", 32'(oe[u]), 32'd0);
        check("desel_busy", 32'(busy[u]), 32'd0);
        check("desel_miso", 32'(miso[u]), 32'd1);
    endtask

    // SPI master: instance 0 is CPOL=0/CPHA=0, instance 1 is CPOL=1/CPHA=1
    task automatic spi_bits(input int u, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic pol;
        pol = (u == 1);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (u == 0) begin
                mosi[u] = mo[7-i];
                wait_clk(H);
                sclk[u] = ~pol;
                mi = {mi[6:0], miso[u]};
                wait_clk(H);
                sclk[u] = pol;
            end else begin
                sclk[u] = ~pol;
                mosi[u] = mo[7-i];
                wait_clk(H);
                sclk[u] = pol;
                mi = {mi[6:0], miso[u]};
                wait_clk(H);
            end
        end
        wait_clk(H);
    endtask

    task automatic xbyte(input int u, input logic [7:0] mo, inout logic [7:0] w, input string tag);
        logic [7:0] mi;
        spi_bits(u, mo, 8, mi);
        check({tag, "_miso"}, 32'(mi), 32'(w));
        model_done(u, mo);
        model_load(u, 1'b0, 8'h00, w);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            check({tag, "_miso"}, 32'(miso[u]), 32'd1);
            check({tag, "_oe"}, 32'(oe[u]), 32'd0);
            check({tag, "_rdata"}, 32'(rdata[u*8 +: 8]), 32'd0);
            check({tag, "_busy"}, 32'(busy[u]), 32'd0);
            check_status(u, tag);
        end
    endtask

    initial begin
        logic [7:0] w, mi;
        rst_n = 1'b0;
        sclk = 2'b10; ss_n = 2'b11; mosi = 2'b00;
        tx_en = 2'b00; rx_en = 2'b00; clr = 2'b00; wdata = 16'h0;
        reset_model();
        wait_clk(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clk(3);

        // mode 0 single byte
        host_write(0, 8'hA5);
        check("m0_txready_full", 32'(txr[0]), 32'd0);
        select(0, 1'b0, 8'h00, w);
        check("m0_txready_after_load", 32'(txr[0]), 32'd1);
        xbyte(0, 8'h3C, w, "m0");
        host_read(0);
        check("m0_rxvalid_cleared", 32'(rxv[0]), 32'd0);
        deselect(0);
        check_status(0, "m0");
        host_clear(0);

        // back-to-back with the buffer refilled during each byte
        host_write(0, 8'h11);
        select(0, 1'b0, 8'h00, w);
        host_write(0, 8'h22);
        xbyte(0, 8'h55, w, "b2b1");
        host_read(0);
        host_write(0, 8'h33);
        xbyte(0, 8'hAA, w, "b2b2");
        host_read(0);
        deselect(0);
        check_status(0, "b2b");

        // underrun and overrun over two unserviced bytes
        select(0, 1'b0, 8'h00, w);
        xbyte(0, 8'h5B, w, "err1");
        xbyte(0, 8'hC4, w, "err2");
        deselect(0);
        check_status(0, "err");
        check("err_rdata_kept", 32'(rdata[7:0]), 32'(m_rdata[0]));
        host_clear(0);
        check_status(0, "err_clr");
        host_read(0);

        // abort after 5 bits, then a clean frame
        select(0, 1'b0, 8'h00, w);
        spi_bits(0, 8'hE7, 5, mi);
        deselect(0);
        check_status(0, "abort");
        host_write(0, 8'h69);
        select(0, 1'b0, 8'h00, w);
        xbyte(0, 8'h96, w, "post_abort");
        host_read(0);
        deselect(0);
        host_clear(0);

        // mode 3 exchange, then bypass write in the load cycle
        host_write(1, 8'hC3);
        select(1, 1'b0, 8'h00, w);
        xbyte(1, 8'h5A, w, "m3");
        host_read(1);
        deselect(1);
        host_clear(1);
        select(1, 1'b1, 8'h7E, w);
        check("bypass_underrun", 32'(und[1]), 32'd0);
        check("bypass_txready", 32'(txr[1]), 32'd1);
        xbyte(1, 8'h81, w, "bypass");
        host_read(1);
        deselect(1);
        host_clear(1);

        for (int n = 0; n < 24; n++) begin
            int u;
            int nb;
            u = $urandom_range(0, 1);
            nb = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) host_write(u, 8'($urandom));
            if ($urandom_range(0, 3) == 0) host_write(u, 8'($urandom));
            select(u, $urandom_range(0, 3) == 0, 8'($urandom), w);
            for (int b = 0; b < nb; b++) begin
                xbyte(u, 8'($urandom), w, "rnd");
                if ($urandom_range(0, 1) == 1) host_read(u);
                if ($urandom_range(0, 1) == 1) host_write(u, 8'($urandom));
            end
            deselect(u);
            check_status(u, "rnd");
            if ($urandom_range(0, 2) == 0) host_clear(u);
        end

        // asynchronous reset in the middle of a byte
        host_write(0, 8'h3A);
        select(0, 1'b0, 8'h00, w);
        spi_bits(0, 8'h0F, 4, mi);
        rst_n = 1'b0;
        #1;
        reset_model();
        check_reset_outputs("async_rst");
        sclk = 2'b10; ss_n = 2'b11;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(3);
        host_write(0, 8'h01);
        select(0, 1'b0, 8'h00, w);
        xbyte(0, 8'h01, w, "recover");
        host_read(0);
        deselect(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Native-RTL SPI slave: the responder end of the link driven by the SPI master top. Single system clock. SCLK, SS_N and MOSI are oversampled through synchronizers. Provides a one-word TX holding buffer and a one-word RX holding register, using the same TX_EN/WDATA and RX_EN/RDATA handshake style as the master IP interface. Sits in the slave-side top between the pins and the slave control FSM.

Parameters:
DATA_WIDTH, 8, frame width in bits, MSB first.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
SYNC_STAGES, 2, synchronizer flops on SCLK/SS_N/MOSI (minimum 2).
IDLE_WORD, 8'hFF, word shifted out when the TX buffer is empty (width DATA_WIDTH).

Ports:
I_CLK  in  1  system clock; must be at least 4x SCLK frequency.
I_RESETN  in  1  reset; asynchronous assert, active-low.
SCLK_SLAVE  in  1  SPI clock from master.
SS_N_SLAVE  in  1  chip select, active-low.
MOSI_SLAVE  in  1  master-to-slave data.
MISO_SLAVE  out  1  slave-to-master data (MSB of shift register).
MISO_OE  out  1  output enable for the MISO pad; high only while selected.
I_TX_EN  in  1  write strobe; accepted only when O_TX_READY=1.
I_WDATA  in  DATA_WIDTH  TX word.
O_TX_READY  out  1  TX buffer empty.
I_RX_EN  in  1  read acknowledge; clears O_RX_VALID.
O_RDATA  out  DATA_WIDTH  last received word.
O_RX_VALID  out  1  O_RDATA holds an unread word.
I_CLR_ERR  in  1  clears the sticky error flags.
O_OVERRUN  out  1  sticky: a word completed while O_RX_VALID=1.
O_UNDERRUN  out  1  sticky: IDLE_WORD was loaded because the TX buffer was empty.
O_BUSY  out  1  high while in LOAD or SHIFT.

Behaviour:
- Reset values: MISO_SLAVE=1, MISO_OE=0, O_TX_READY=1, O_RDATA=0, O_RX_VALID=0, O_OVERRUN=0, O_UNDERRUN=0, O_BUSY=0. Synchronizer flops reset to idle (SCLK=CPOL, SS_N=1). State = IDLE.
- Edge detection is done on the synchronized signals only. Leading edge = SCLK transition away from CPOL; trailing edge = transition back to CPOL.
- FSM IDLE:
  - Synchronized SS_N falling edge -> LOAD.
- FSM LOAD (1 cycle):
  - If the TX buffer is full, load it into the shift register and set O_TX_READY=1.
  - Else if I_TX_EN=1 this cycle, bypass I_WDATA straight into the shift register; O_TX_READY stays 1 and no underrun is flagged.
  - Else load IDLE_WORD and set O_UNDERRUN.
  - Clear the bit counter. Set MISO_OE=1. -> SHIFT.
- FSM SHIFT, CPHA=0:
  - Leading edge: sample MOSI into the receive shift register and increment the bit counter.
  - Trailing edges 1..DATA_WIDTH-1: shift out the next MISO bit.
  - Trailing edge DATA_WIDTH: word-complete handling (below), then reload the shift register as in LOAD.
- FSM SHIFT, CPHA=1:
  - Leading edge 1: no shift (MSB is already on MISO).
  - Leading edges 2..DATA_WIDTH: shift out the next bit.
  - Trailing edge: sample MOSI. Trailing edge DATA_WIDTH: word-complete handling, then reload.
- Word complete:
  - If O_RX_VALID=0, or I_RX_EN=1 in the same cycle: O_RDATA <= received word, O_RX_VALID=1.
  - Otherwise set O_OVERRUN; O_RDATA keeps the old word and the new word is dropped.
- Latency: O_RX_VALID rises SYNC_STAGES+1 I_CLK cycles after the final sampling SCLK edge at the pin.
- Read acknowledge: I_RX_EN with O_RX_VALID=1 clears O_RX_VALID on the next edge. I_RX_EN with O_RX_VALID=0 is ignored.
- TX writes:
  - I_TX_EN with O_TX_READY=1 captures I_WDATA and drops O_TX_READY on the next edge.
  - I_TX_EN with O_TX_READY=0 is ignored; the buffer is not overwritten.
- Synchronized SS_N rising edge, from any state:
  - Go to IDLE, discard any partial word (no RX_VALID, no overrun), set MISO_OE=0 and MISO_SLAVE=1.
  - The TX buffer is untouched. A word already moved to the shift register is lost.
- SS_N falling and rising in the same cycle are not possible (synchronized single signal). A glitch shorter than 1 I_CLK cycle may be missed; no requirement applies.
- Flag clearing: I_CLR_ERR clears both sticky flags. A set event in the same cycle wins.
- Asynchronous reset mid-frame returns every output to its reset value immediately.

Test Plan:
- Mode 0 single byte: write 8'hA5, then the master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; O_RDATA=8'h3C; O_RX_VALID high for 1 word; O_TX_READY=1 after LOAD.
- Back-to-back: SS_N held low for 2 bytes, TX writes 8'h11 then 8'h22 -> MISO carries 11 then 22, O_RDATA sequence 8'h55 then 8'hAA (master data), each read by I_RX_EN; no error flags set.
- Underrun/overrun: no TX write and no I_RX_EN over 2 bytes -> MISO=8'hFF each byte, O_UNDERRUN=1, O_OVERRUN=1, O_RDATA holds byte 1; I_CLR_ERR -> both flags 0.
- Abort: SS_N deasserted after 5 SCLK bits -> O_RX_VALID stays 0, MISO_OE=0, state IDLE; the next full frame 8'h96 is received correctly.
- CPOL=1, CPHA=1 build: exchange 8'hC3 / 8'h5A -> both sides are bit-exact. Also TX write in the same cycle as LOAD with the buffer empty -> bypass word is sent and O_UNDERRUN=0.
- Async reset asserted mid-byte -> all outputs are at reset values within the same cycle; recovery frame 8'h01 is correct.
